// File: rtl/ddr3_pixel_reader_burst_if.sv
// DDR3 frame reader bundle: control, Avalon-MM burst read
// channel and the unpacked pixel stream.
interface ddr3_pixel_reader_burst_if #(
  parameter int OUT_WIDTH = 32
);
  logic                 start;
  logic                 busy;
  logic                 frame_done;
  logic [26:0]          ddr3_read_address;
  logic                 ddr3_read;
  logic [7:0]           ddr3_burstcount;
  logic                 ddr3_waitrequest;
  logic [255:0]         ddr3_readdata;
  logic                 ddr3_readdatavalid;
  logic [OUT_WIDTH-1:0] pixel_out;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic [7:0]           fifo_level;
  logic                 fifo_overflow;

  modport master (
    input  start,
    output busy, frame_done,
    output ddr3_read_address, ddr3_read, ddr3_burstcount,
    input  ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
    output pixel_out, pixel_valid,
    input  pixel_ready,
    output fifo_level, fifo_overflow
  );

  modport slave (
    output start,
    input  busy, frame_done,
    input  ddr3_read_address, ddr3_read, ddr3_burstcount,
    output ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
    input  pixel_out, pixel_valid,
    output pixel_ready,
    input  fifo_level, fifo_overflow
  );
endinterface

// File: rtl/ddr3_pixel_reader_burst.sv
// DDR3 burst frame reader: fetches 256-bit words into a FIFO and
// unpacks them LSB-first. Define DDR3_READER_LOOP_EN to loop frames.
module ddr3_pixel_reader_burst #(
  parameter int          BURST_LEN  = 8,
  parameter int          NUM_WORDS  = 86400,
  parameter logic [26:0] START_ADDR = 27'h1B00000,
  parameter int          OUT_WIDTH  = 32,
  parameter int          FIFO_DEPTH = 32
) (
  input logic ddr3_clk,
  input logic ddr3_clk_reset,
  ddr3_pixel_reader_burst_if.master bus
);
  localparam int OW     = $clog2(FIFO_DEPTH + 1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int SLICES = 256 / OUT_WIDTH;
  localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_DRAIN
  } state_t;

  state_t         state, state_nx;
  logic [26:0]    addr;
  logic [31:0]    words;
  logic [OW-1:0]  outstanding;
  logic [255:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [OW-1:0]  count;
  logic           overflow;
  logic [255:0]   word;
  logic [IW-1:0]  idx;
  logic           pix_valid;

  logic load, cmd_acc, last_burst, done;
  logic beat, full, wr_en, rd_en, take, space_ok;

  assign last_burst = (words == 32'(NUM_WORDS - BURST_LEN));
  assign space_ok   = (32'(count) + 32'(outstanding) + 32'(BURST_LEN))
                      <= 32'(FIFO_DEPTH);
  assign beat  = bus.ddr3_readdatavalid && (state != ST_IDLE);
  assign full  = (count == OW'(FIFO_DEPTH));
  assign wr_en = beat && !full;
  assign take  = pix_valid && bus.pixel_ready;
  assign rd_en = (count != '0) &&
                 (!pix_valid || (take && idx == LAST));
  assign done  = (state == ST_DRAIN) && (outstanding == '0) &&
                 (count == '0) && !pix_valid;

  assign bus.busy              = (state != ST_IDLE);
  assign bus.frame_done        = done;
  assign bus.ddr3_read         = (state == ST_REQ);
  assign bus.ddr3_read_address = addr;
  assign bus.ddr3_burstcount   = 8'(BURST_LEN);
  assign bus.pixel_out         = word[OUT_WIDTH-1:0];
  assign bus.pixel_valid       = pix_valid;
  assign bus.fifo_level        = 8'(count);
  assign bus.fifo_overflow     = overflow;

  // Next-state and command strobes of the burst request FSM
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    cmd_acc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (space_ok) state_nx = ST_REQ;
      end
      ST_REQ: begin
        if (!bus.ddr3_waitrequest) begin
          cmd_acc  = 1'b1;
          state_nx = last_burst ? ST_DRAIN : ST_WAIT_SPACE;
        end
      end
      ST_DRAIN: begin
        if (done) begin
`ifdef DDR3_READER_LOOP_EN
          load     = 1'b1;
          state_nx = ST_WAIT_SPACE;
`else
          state_nx = ST_IDLE;
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, address, issued-word and in-flight beat counters
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_clk_reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      words       <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        addr        <= START_ADDR;
        words       <= '0;
        outstanding <= '0;
      end else begin
        if (cmd_acc) begin
          words <= words + 32'(BURST_LEN);
          if (!last_burst) addr <= addr + 27'(BURST_LEN);
        end
        outstanding <= outstanding
                     + (cmd_acc ? OW'(BURST_LEN) : '0)
                     - OW'(beat);
      end
    end
  end

  // FIFO storage, written by accepted read beats
  always_ff @(posedge ddr3_clk) begin
    if (wr_en) mem[wr_ptr] <= bus.ddr3_readdata;
  end

  // FIFO pointers, fill level and sticky overflow flag
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_clk_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + OW'(wr_en) - OW'(rd_en);
      if (beat && full) overflow <= 1'b1;
    end
  end

  // Unpacker: reload from FIFO on the last slice without a bubble
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_clk_reset) begin
      word      <= '0;
      idx       <= '0;
      pix_valid <= 1'b0;
    end else if (rd_en) begin
      word      <= mem[rd_ptr];
      idx       <= '0;
      pix_valid <= 1'b1;
    end else if (take) begin
      word <= word >> OUT_WIDTH;
      idx  <= idx + IW'(1);
      if (idx == LAST) pix_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr3_pixel_reader_burst.sv
// Bench for ddr3_pixel_reader_burst: 5-cycle-latency memory model,
// expected commands/pixels queued at start, checked by monitors.
`timescale 1ns/1ps
module tb_ddr3_pixel_reader_burst;
  localparam int BL = 8;
  localparam int NW = 64;
  localparam int PX = 32;
  localparam int FD = 32;
  localparam logic [26:0] SA = 27'h1B00000;

  typedef struct packed {
    int          due;
    logic [26:0] a;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr3_pixel_reader_burst_if #(.OUT_WIDTH(PX)) bus ();

  ddr3_pixel_reader_burst #(
    .BURST_LEN (BL),
    .NUM_WORDS (NW),
    .START_ADDR(SA),
    .OUT_WIDTH (PX),
    .FIFO_DEPTH(FD)
  ) dut (
    .ddr3_clk      (clk),
    .ddr3_clk_reset(rst),
    .bus           (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pix[$];
  logic [26:0] exp_cmd[$];
  int          stall_q[$];
  beat_t       bq[$];
  int cyc = 0, last_due = 0, model_out = 0;
  int cmd_cnt = 0, done_cnt = 0, stall_left = 0;
  int sim_pre = 0;
  bit discard = 1'b1, in_cmd = 1'b0, just_acc = 1'b0;
  bit sim_pend = 1'b0, acc, bt;
  logic [26:0] cmd_addr, ce, ba;
  logic [31:0] pe;
  time first_beat_t = 0, first_pix_t = 0;
  bit  seen_beat = 1'b0, seen_pix = 1'b0;
  int  d;

  task automatic chk(string nm, bit ok, longint act, longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mkword(logic [26:0] a);
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = {a[23:0], 8'(j)};
    return w;
  endfunction

  // Memory model, command checks and in-flight beat model
  always @(negedge clk) begin
    acc = 1'b0;
    bt  = 1'b0;
    cyc++;
    chk("outstanding", int'(dut.outstanding) == model_out,
        dut.outstanding, model_out);
    chk("level_max", int'(bus.fifo_level) <= FD, bus.fifo_level, FD);
    chk("no_overflow", bus.fifo_overflow == 1'b0,
        bus.fifo_overflow, 0);
    if (sim_pend) begin
      chk("simul_plus7", int'(dut.outstanding) == sim_pre + 7,
          dut.outstanding, sim_pre + 7);
      sim_pend = 1'b0;
    end
    if (just_acc) begin
      chk("read_gap", bus.ddr3_read == 1'b0, bus.ddr3_read, 0);
      just_acc = 1'b0;
    end
    if (bus.frame_done) done_cnt++;
    if (bus.ddr3_read) begin
      if (!in_cmd) begin
        in_cmd     = 1'b1;
        cmd_addr   = bus.ddr3_read_address;
        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
      end else begin
        chk("addr_stable", bus.ddr3_read_address == cmd_addr,
            bus.ddr3_read_address, cmd_addr);
      end
      if (stall_left > 0) begin
        bus.ddr3_waitrequest = 1'b1;
        stall_left--;
      end else begin
        bus.ddr3_waitrequest = 1'b0;
        acc      = !rst;
        in_cmd   = 1'b0;
        just_acc = !rst;
      end
    end else begin
      bus.ddr3_waitrequest = 1'b0;
      in_cmd = 1'b0;
    end
    if (acc) begin
      cmd_cnt++;
      chk("space", FD - int'(bus.fifo_level) - model_out >= BL,
          FD - int'(bus.fifo_level) - model_out, BL);
      chk("cmd_expected", exp_cmd.size() != 0, cmd_addr, 0);
      if (exp_cmd.size() != 0) begin
        ce = exp_cmd.pop_front();
        chk("cmd_addr", cmd_addr == ce, cmd_addr, ce);
      end
      for (int i = 0; i < BL; i++) begin
        d = (cyc + 5 > last_due + 1) ? cyc + 5 : last_due + 1;
        bq.push_back('{d, 27'(cmd_addr + 27'(i))});
        last_due = d;
      end
    end
    if (bq.size() > 0 && bq[0].due <= cyc) begin
      ba = bq[0].a;
      void'(bq.pop_front());
      bus.ddr3_readdatavalid = 1'b1;
      bus.ddr3_readdata      = mkword(ba);
      bt = 1'b1;
      if (!seen_beat) begin
        seen_beat    = 1'b1;
        first_beat_t = $time;
      end
    end else begin
      bus.ddr3_readdatavalid = 1'b0;
      bus.ddr3_readdata      = '0;
    end
    if (rst) begin
      model_out = 0;
      discard   = 1'b1;
    end else begin
      if (acc && bt && !discard) begin
        sim_pend = 1'b1;
        sim_pre  = model_out;
      end
      if (acc) model_out += BL;
      if (bt && !discard) model_out--;
      if (bus.start && !bus.busy) discard = 1'b0;
    end
  end

  // Pixel scoreboard monitor
  always @(negedge clk) begin
    if (bus.pixel_valid && !seen_pix) begin
      seen_pix    = 1'b1;
      first_pix_t = $time;
    end
    if (bus.pixel_valid && bus.pixel_ready) begin
      chk("pix_expected", exp_pix.size() != 0, bus.pixel_out, 0);
      if (exp_pix.size() != 0) begin
        pe = exp_pix.pop_front();
        chk("pixel", bus.pixel_out == pe, bus.pixel_out, pe);
      end
    end
  end

  task automatic push_frame();
    logic [26:0] a;
    for (int w = 0; w < NW; w++) begin
      a = 27'(SA + 27'(w));
      if (w % BL == 0) exp_cmd.push_back(a);
      for (int j = 0; j < 8; j++) exp_pix.push_back({a[23:0], 8'(j)});
    end
  endtask

  task automatic start_pulse();
    cmd_cnt   = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(int target, int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) break;
      @(posedge clk); #1;
    end
    chk("done_timeout", done_cnt >= target, done_cnt, target);
  endtask

  task automatic end_frame(int target);
    chk("busy_fall", bus.busy == 1'b0, bus.busy, 0);
    chk("cmd_count", cmd_cnt == NW / BL, cmd_cnt, NW / BL);
    chk("pix_left", exp_pix.size() == 0, exp_pix.size(), 0);
    chk("cmd_left", exp_cmd.size() == 0, exp_cmd.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_once", done_cnt == target, done_cnt, target);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.pixel_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", bus.ddr3_read == 1'b0, bus.ddr3_read, 0);
    chk("rst_addr", bus.ddr3_read_address == 27'd0,
        bus.ddr3_read_address, 0);
    chk("rst_busy", bus.busy == 1'b0, bus.busy, 0);
    chk("rst_done", bus.frame_done == 1'b0, bus.frame_done, 0);
    chk("rst_pvalid", bus.pixel_valid == 1'b0, bus.pixel_valid, 0);
    chk("rst_level", bus.fifo_level == 8'd0, bus.fifo_level, 0);
    chk("rst_ovf", bus.fifo_overflow == 1'b0, bus.fifo_overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef DDR3_READER_LOOP_EN
    push_frame();
    push_frame();
    push_frame();
    start_pulse();
    wait_done(1, 3000);
    chk("loop_busy1", bus.busy == 1'b1, bus.busy, 1);
    wait_done(2, 3000);
    chk("loop_busy2", bus.busy == 1'b1, bus.busy, 1);
    chk("loop_cmds", cmd_cnt == 2 * NW / BL, cmd_cnt, 2 * NW / BL);
    for (int i = 0; i < 30; i++) begin
      if (exp_cmd.size() < NW / BL) break;
      @(posedge clk); #1;
    end
    chk("loop_restart", exp_cmd.size() == NW / BL - 1,
        exp_cmd.size(), NW / BL - 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pix.delete();
    exp_cmd.delete();
    chk("loop_rst_busy", bus.busy == 1'b0, bus.busy, 0);
`else
    push_frame();
    bus.start = 1'b1;
    cmd_cnt   = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("lat_busy", bus.busy == 1'b1, bus.busy, 1);
    chk("lat_read_c1", bus.ddr3_read == 1'b0, bus.ddr3_read, 0);
    @(posedge clk); #1;
    chk("lat_read_c2", bus.ddr3_read == 1'b1, bus.ddr3_read, 1);
    wait_done(1, 3000);
    end_frame(1);
    chk("beat2pix", (first_pix_t - first_beat_t) <= 30,
        first_pix_t - first_beat_t, 30);

    stall_q = '{7, 5};
    push_frame();
    start_pulse();
    wait_done(2, 3000);
    end_frame(2);

    bus.pixel_ready = 1'b0;
    push_frame();
    start_pulse();
    repeat (200) @(posedge clk);
    #1;
    chk("bp_level", bus.fifo_level == 8'd31, bus.fifo_level, 31);
    chk("bp_cmds", cmd_cnt == 4, cmd_cnt, 4);
    chk("bp_hold", bus.pixel_valid == 1'b1, bus.pixel_valid, 1);
    bus.pixel_ready = 1'b1;
    wait_done(3, 3000);
    end_frame(3);

    stall_q = '{0, 200};
    push_frame();
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      if (model_out == 6) break;
      @(posedge clk); #1;
    end
    chk("rst_six_out", model_out == 6, model_out, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pix.delete();
    exp_cmd.delete();
    stall_q.delete();
    chk("mid_busy", bus.busy == 1'b0, bus.busy, 0);
    chk("mid_read", bus.ddr3_read == 1'b0, bus.ddr3_read, 0);
    chk("mid_pvalid", bus.pixel_valid == 1'b0, bus.pixel_valid, 0);
    for (int i = 0; i < 50; i++) begin
      if (bq.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("inflight_gone", bq.size() == 0, bq.size(), 0);
    @(posedge clk); #1;
    chk("drop_level", bus.fifo_level == 8'd0, bus.fifo_level, 0);
    chk("drop_pvalid", bus.pixel_valid == 1'b0, bus.pixel_valid, 0);

    push_frame();
    start_pulse();
    wait_done(4, 3000);
    end_frame(4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
